window_3x3_gen: RTL and testbench

// Consumes the raster pixel stream read out of the image BRAM (one pixel per clk_rd) and

---
 rtl/window_3x3_gen.sv | 185 ++++++++++++++++++
 tb/tb_window_3x3_gen.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// window_3x3_gen
// Turns a raster pixel stream into 3x3 neighbourhood windows for every interior pixel.
// Two line buffers hold the previous two rows. A two-column shift array holds the left
// two columns of the window. The incoming column completes the window, which is
// registered on the cycle after the centre's lower-right neighbour arrives.

module window_3x3_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256
) (
    input  logic                       clk_rd,
    input  logic                       reset_rd,
    input  logic                       pix_valid,
    input  logic                       pix_sof,
    input  logic [DATA_W-1:0]          pix_data,
    output logic                       win_valid,
    output logic [9*DATA_W-1:0]        win,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       frame_done,
    output logic                       err_sync,
    output logic                       busy
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [COL_W-1:0]       col_q, col_d;

    logic [DATA_W-1:0]      lb0_q [IMG_W];
    logic [DATA_W-1:0]      lb1_q [IMG_W];

    logic [DATA_W-1:0]      sh0_q [3];
    logic [DATA_W-1:0]      sh0_d [3];
    logic [DATA_W-1:0]      sh1_q [3];
    logic [DATA_W-1:0]      sh1_d [3];

    logic                   winValid_q, winValid_d;
    logic [9*DATA_W-1:0]    win_q, win_d;
    logic [ROW_W-1:0]       winRow_q, winRow_d;
    logic [COL_W-1:0]       winCol_q, winCol_d;
    logic                   frameDone_q, frameDone_d;
    logic                   errSync_q, errSync_d;
    logic                   busy_q, busy_d;

    logic                   inFrame;
    logic                   accept;
    logic [ROW_W-1:0]       curRow;
    logic [COL_W-1:0]       curCol;
    logic [DATA_W-1:0]      lbRd0;
    logic [DATA_W-1:0]      lbRd1;

    // Decide whether this pixel is taken, where it sits, and compute every next-state value.
    always_comb begin
        inFrame = (state_q == FILL) || (state_q == STREAM);
        accept  = pix_valid && (pix_sof || inFrame);
        curRow  = pix_sof ? '0 : row_q;
        curCol  = pix_sof ? '0 : col_q;
        lbRd0   = lb0_q[curCol];
        lbRd1   = lb1_q[curCol];

        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        winValid_d  = 1'b0;
        win_d       = win_q;
        winRow_d    = winRow_q;
        winCol_d    = winCol_q;
        frameDone_d = 1'b0;
        errSync_d   = 1'b0;

        if (accept) begin
            sh0_d    = sh1_q;
            sh1_d[0] = lbRd1;
            sh1_d[1] = lbRd0;
            sh1_d[2] = pix_data;

            if (pix_sof) begin
                state_d = FILL;
            end

            if (curCol == COL_LAST) begin
                col_d = '0;
                row_d = curRow + ROW_W'(1);
            end else begin
                col_d = curCol + COL_W'(1);
                row_d = curRow;
            end

            if (curRow >= ROW_TWO && curCol >= COL_TWO) begin
                winValid_d = 1'b1;
                winRow_d   = curRow - ROW_W'(1);
                winCol_d   = curCol - COL_W'(1);
                for (int i = 0; i < 3; i++) begin
                    win_d[DATA_W*(3*i)   +: DATA_W] = sh0_q[i];
                    win_d[DATA_W*(3*i+1) +: DATA_W] = sh1_q[i];
                    win_d[DATA_W*(3*i+2) +: DATA_W] = sh1_d[i];
                end
            end

            if (state_q == FILL && curRow == ROW_ONE && curCol == COL_LAST) begin
                state_d = STREAM;
            end

            if (curRow == ROW_LAST && curCol == COL_LAST) begin
                state_d     = DONE;
                frameDone_d = 1'b1;
                row_d       = '0;
                col_d       = '0;
            end
        end else if (pix_valid) begin
            errSync_d = 1'b1;
        end

        busy_d = (state_d == FILL) || (state_d == STREAM);
    end

    // Frame FSM, position counters, column shift array and registered outputs.
    always_ff @(posedge clk_rd) begin
        if (reset_rd) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            for (int i = 0; i < 3; i++) begin
                sh0_q[i] <= '0;
                sh1_q[i] <= '0;
            end
            winValid_q  <= 1'b0;
            win_q       <= '0;
            winRow_q    <= '0;
            winCol_q    <= '0;
            frameDone_q <= 1'b0;
            errSync_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            winValid_q  <= winValid_d;
            win_q       <= win_d;
            winRow_q    <= winRow_d;
            winCol_q    <= winCol_d;
            frameDone_q <= frameDone_d;
            errSync_q   <= errSync_d;
            busy_q      <= busy_d;
        end
    end

    // Line buffers: row r-1 moves down to the r-2 buffer as the new pixel replaces it.
    always_ff @(posedge clk_rd) begin
        if (accept && !reset_rd) begin
            lb1_q[curCol] <= lbRd0;
            lb0_q[curCol] <= pix_data;
        end
    end

    assign win_valid  = winValid_q;
    assign win        = win_q;
    assign win_row    = winRow_q;
    assign win_col    = winCol_q;
    assign frame_done = frameDone_q;
    assign err_sync   = errSync_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen
// Self-checking bench for window_3x3_gen on an 8x6 image. A table of short control sequences
// is followed by hand-written frame scenarios and randomized traffic. All outputs are compared
// each cycle against an image-array reference model.

module tb_window_3x3_gen;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;

    logic             clk_rd;
    logic             reset_rd;
    logic             pix_valid;
    logic             pix_sof;
    logic [DW-1:0]    pix_data;
    logic             win_valid;
    logic [9*DW-1:0]  win;
    logic [2:0]       win_row;
    logic [2:0]       win_col;
    logic             frame_done;
    logic             err_sync;
    logic             busy;

    window_3x3_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk_rd     (clk_rd),
        .reset_rd   (reset_rd),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_data   (pix_data),
        .win_valid  (win_valid),
        .win        (win),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done),
        .err_sync   (err_sync),
        .busy       (busy)
    );

    // Free-running clock.
    initial begin
        clk_rd = 1'b0;
        forever #5 clk_rd = ~clk_rd;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: pixels of the current frame kept as a plain 2D image.
    logic [DW-1:0]    img [H][W];
    bit               mInFrame;
    int               mR;
    int               mC;
    bit               eValid;
    bit               eDone;
    bit               eErr;
    bit               eBusy;
    logic [9*DW-1:0]  eWin;
    logic [2:0]       eRow;
    logic [2:0]       eCol;

    // Tallies observed on the DUT outputs for scenario checks.
    int               winCount;
    int               doneCount;
    logic [9*DW-1:0]  firstWin;
    logic [2:0]       firstRow;
    logic [2:0]       firstCol;
    logic [9*DW-1:0]  doneWin;
    logic [2:0]       doneRow;
    logic [2:0]       doneCol;

    typedef struct {
        bit            rst;
        bit            v;
        bit            sof;
        logic [7:0]    d;
        bit            xValid;
        bit            xDone;
        bit            xErr;
        bit            xBusy;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [9*DW-1:0] got, input logic [9*DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic modelStep(input bit rst, input bit v, input bit sof, input logic [DW-1:0] d);
        int r;
        int c;
        eValid = 1'b0;
        eDone  = 1'b0;
        eErr   = 1'b0;
        if (rst) begin
            mInFrame = 1'b0;
            mR = 0;
            mC = 0;
            eWin = '0;
            eRow = '0;
            eCol = '0;
            eBusy = 1'b0;
            return;
        end
        if (v && (sof || mInFrame)) begin
            r = sof ? 0 : mR;
            c = sof ? 0 : mC;
            img[r][c] = d;
            mInFrame = 1'b1;
            if (r >= 2 && c >= 2) begin
                eValid = 1'b1;
                eRow = 3'(r - 1);
                eCol = 3'(c - 1);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        eWin[DW*(3*i+j) +: DW] = img[r-2+i][c-2+j];
            end
            if (r == H-1 && c == W-1) begin
                eDone = 1'b1;
                mInFrame = 1'b0;
            end
            c++;
            if (c == W) begin
                c = 0;
                r++;
            end
            mR = r;
            mC = c;
        end else if (v) begin
            eErr = 1'b1;
        end
        eBusy = mInFrame;
    endtask

    task automatic checkOutput();
        check("win_valid",  {71'd0, win_valid},  {71'd0, eValid});
        check("frame_done", {71'd0, frame_done}, {71'd0, eDone});
        check("err_sync",   {71'd0, err_sync},   {71'd0, eErr});
        check("busy",       {71'd0, busy},       {71'd0, eBusy});
        check("win",        win,                 eWin);
        check("win_row",    {69'd0, win_row},    {69'd0, eRow});
        check("win_col",    {69'd0, win_col},    {69'd0, eCol});
    endtask

    task automatic tally();
        if (win_valid === 1'b1) begin
            if (winCount == 0) begin
                firstWin = win;
                firstRow = win_row;
                firstCol = win_col;
            end
            winCount++;
        end
        if (frame_done === 1'b1) begin
            doneCount++;
            doneWin = win;
            doneRow = win_row;
            doneCol = win_col;
        end
    endtask

    task automatic clearTally();
        winCount  = 0;
        doneCount = 0;
        firstWin  = '0;
        firstRow  = '0;
        firstCol  = '0;
        doneWin   = '0;
        doneRow   = '0;
        doneCol   = '0;
    endtask

    // One clock: drive inputs, predict, then sample outputs one unit after the edge.
    task automatic applyStimulus(input bit rst, input bit v, input bit sof, input logic [DW-1:0] d);
        reset_rd  = rst;
        pix_valid = v;
        pix_sof   = sof;
        pix_data  = d;
        modelStep(rst, v, sof, d);
        @(posedge clk_rd);
        #1;
        checkOutput();
        tally();
    endtask

    // Raster frame starting with sof; stops before linear index stopAt.
    task automatic sendFrame(input int bubblePct, input int stopAt, input bit randData);
        logic [DW-1:0] d;
        for (int k = 0; k < stopAt; k++) begin
            for (int b = 0; b < 5 && int'($urandom_range(99)) < bubblePct; b++)
                applyStimulus(1'b0, 1'b0, 1'b0, DW'($urandom));
            d = randData ? DW'($urandom) : DW'(((k / W) % 16) * 16 + (k % W));
            applyStimulus(1'b0, 1'b1, (k == 0), d);
        end
    endtask

    task automatic checkFullFrame(input string tag);
        check({tag, " first_row"},  {69'd0, firstRow}, 72'd1);
        check({tag, " first_col"},  {69'd0, firstCol}, 72'd1);
        check({tag, " first_tl"},   {64'd0, firstWin[7:0]},   72'h00);
        check({tag, " first_ctr"},  {64'd0, firstWin[39:32]}, 72'h11);
        check({tag, " first_br"},   {64'd0, firstWin[71:64]}, 72'h22);
        check({tag, " win_count"},  72'(winCount),  72'd24);
        check({tag, " done_count"}, 72'(doneCount), 72'd1);
        check({tag, " done_row"},   {69'd0, doneRow}, 72'd4);
        check({tag, " done_col"},   {69'd0, doneCol}, 72'd6);
        check({tag, " done_br"},    {64'd0, doneWin[71:64]}, 72'h57);
    endtask

    function automatic vec_t mkVec(bit rst, bit v, bit sof, logic [7:0] d,
                                   bit xv, bit xd, bit xe, bit xb);
        vec_t t;
        t.rst = rst; t.v = v; t.sof = sof; t.d = d;
        t.xValid = xv; t.xDone = xd; t.xErr = xe; t.xBusy = xb;
        return t;
    endfunction

    // Main test sequence.
    initial begin
        reset_rd  = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = '0;
        clearTally();

        tbl[0]  = mkVec(1, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[1]  = mkVec(1, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[2]  = mkVec(1, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[3]  = mkVec(0, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[4]  = mkVec(0, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[5]  = mkVec(0, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[6]  = mkVec(0, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[7]  = mkVec(0, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[8]  = mkVec(0, 1, 0, 8'hAA, 0, 0, 1, 0);
        tbl[9]  = mkVec(0, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[10] = mkVec(0, 0, 1, 8'h00, 0, 0, 0, 0);
        tbl[11] = mkVec(0, 1, 1, 8'h00, 0, 0, 0, 1);
        tbl[12] = mkVec(0, 0, 0, 8'h00, 0, 0, 0, 1);
        tbl[13] = mkVec(1, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[14] = mkVec(0, 1, 0, 8'h55, 0, 0, 1, 0);
        tbl[15] = mkVec(1, 0, 0, 8'h00, 0, 0, 0, 0);

        // Reset, idle, stray pixel and sof handling from the table.
        for (int n = 0; n < 16; n++) begin
            reset_rd  = tbl[n].rst;
            pix_valid = tbl[n].v;
            pix_sof   = tbl[n].sof;
            pix_data  = tbl[n].d;
            modelStep(tbl[n].rst, tbl[n].v, tbl[n].sof, tbl[n].d);
            @(posedge clk_rd);
            #1;
            check($sformatf("tbl%0d win_valid", n),  {71'd0, win_valid},  {71'd0, tbl[n].xValid});
            check($sformatf("tbl%0d frame_done", n), {71'd0, frame_done}, {71'd0, tbl[n].xDone});
            check($sformatf("tbl%0d err_sync", n),   {71'd0, err_sync},   {71'd0, tbl[n].xErr});
            check($sformatf("tbl%0d busy", n),       {71'd0, busy},       {71'd0, tbl[n].xBusy});
            if (tbl[n].rst) begin
                check($sformatf("tbl%0d win_zero", n), win, 72'd0);
                check($sformatf("tbl%0d pos_zero", n), {66'd0, win_row, win_col}, 72'd0);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Full frame without bubbles.
        clearTally();
        sendFrame(0, W*H, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkFullFrame("full");

        // Stray pixel after the frame ends.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h33);
        check("post_frame err", {71'd0, err_sync}, 72'd1);
        check("post_frame busy", {71'd0, busy}, 72'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        check("post_frame err_clear", {71'd0, err_sync}, 72'd0);

        // Same frame with bubbles.
        clearTally();
        sendFrame(30, W*H, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkFullFrame("bubbles");

        // Restart with sof at (3,4).
        clearTally();
        sendFrame(0, 3*W + 4, 1'b0);
        sendFrame(0, W*H, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        check("restart win_count",  72'(winCount),  72'd32);
        check("restart done_count", 72'(doneCount), 72'd1);

        // Reset at (4,3), then a clean frame.
        sendFrame(0, 4*W + 3, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h43);
        check("midreset busy", {71'd0, busy}, 72'd0);
        check("midreset win",  win, 72'd0);
        clearTally();
        sendFrame(0, W*H, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkFullFrame("after_reset");

        // Random data frames with bubbles.
        for (int f = 0; f < 3; f++)
            sendFrame(40, W*H, 1'b1);

        // Unconstrained random traffic.
        for (int n = 0; n < 600; n++)
            applyStimulus(($urandom_range(99) < 1), ($urandom_range(99) < 75),
                          ($urandom_range(99) < 3), DW'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
